div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 136 +++++++++++++
 tb/tb_div_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative signed 32-bit divider: one restoring step per clock, sign fix-up on the final cycle.
// Optional divide-by-zero detection is enabled by defining DIV_ZERO_DETECT_EN.
module div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        CtrlDiv,
  output logic        DivStop,
  output logic [31:0] DivHI_out,
  output logic [31:0] DivLO_out,
  output logic        DivZero
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] FIX  = 2'b10;

  logic [1:0]    state, state_d;
  logic [CW-1:0] count, count_d;
  logic [W-1:0]  rem, rem_d;
  logic [W-1:0]  quo, quo_d;
  logic [W-1:0]  dvs, dvs_d;
  logic          sign_r, sign_r_d;
  logic          sign_q, sign_q_d;
  logic          stop_d, zero_d;
  logic [W-1:0]  hi_d, lo_d;

  logic [W-1:0]  abs_a_c, abs_b_c;
  logic [W:0]    rem_sh_c, diff_c;
  logic          start_c, zero_hit_c;

  // Magnitudes wrap in 32 bits, so the most negative value maps onto itself.
  assign abs_a_c = a[W-1] ? (~a + W'(1)) : a;
  assign abs_b_c = b[W-1] ? (~b + W'(1)) : b;

  assign rem_sh_c = {rem, quo[W-1]};
  assign diff_c   = rem_sh_c - {1'b0, dvs};

`ifdef DIV_ZERO_DETECT_EN
  assign start_c    = CtrlDiv && (b != '0);
  assign zero_hit_c = CtrlDiv && (b == '0);
`else
  assign start_c    = CtrlDiv;
  assign zero_hit_c = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state;
    count_d  = count;
    rem_d    = rem;
    quo_d    = quo;
    dvs_d    = dvs;
    sign_r_d = sign_r;
    sign_q_d = sign_q;
    stop_d   = 1'b0;
    zero_d   = DivZero;
    hi_d     = DivHI_out;
    lo_d     = DivLO_out;

    case (state)
      IDLE: begin
        if (start_c) begin
          rem_d    = '0;
          quo_d    = abs_a_c;
          dvs_d    = abs_b_c;
          sign_r_d = a[W-1];
          sign_q_d = a[W-1] ^ b[W-1];
          zero_d   = 1'b0;
          count_d  = CW'(W);
          state_d  = RUN;
        end else if (zero_hit_c) begin
          zero_d = 1'b1;
          stop_d = 1'b1;
        end
      end
      RUN: begin
        // A borrow out of the trial subtraction means restore.
        if (diff_c[W]) begin
          rem_d = rem_sh_c[W-1:0];
          quo_d = {quo[W-2:0], 1'b0};
        end else begin
          rem_d = diff_c[W-1:0];
          quo_d = {quo[W-2:0], 1'b1};
        end
        count_d = count - CW'(1);
        if (count == CW'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        lo_d    = sign_q ? (~quo + W'(1)) : quo;
        hi_d    = sign_r ? (~rem + W'(1)) : rem;
        stop_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      sign_r    <= 1'b0;
      sign_q    <= 1'b0;
      DivStop   <= 1'b0;
      DivZero   <= 1'b0;
      DivHI_out <= '0;
      DivLO_out <= '0;
    end else begin
      state     <= state_d;
      count     <= count_d;
      rem       <= rem_d;
      quo       <= quo_d;
      dvs       <= dvs_d;
      sign_r    <= sign_r_d;
      sign_q    <= sign_q_d;
      DivStop   <= stop_d;
      DivZero   <= zero_d;
      DivHI_out <= hi_d;
      DivLO_out <= lo_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results queued at issue, compared on DivStop.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic        CtrlDiv;
  logic        DivStop;
  logic [31:0] DivHI_out, DivLO_out;
  logic        DivZero;

  always #5 clk = ~clk;

  div_unit dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a),
    .b        (b),
    .CtrlDiv  (CtrlDiv),
    .DivStop  (DivStop),
    .DivHI_out(DivHI_out),
    .DivLO_out(DivLO_out),
    .DivZero  (DivZero)
  );

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        zero;
    int          done;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          nchecks = 0;
  int          nerrors = 0;
  logic [31:0] last_lo = '0;
  logic [31:0] last_hi = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference result via the language's unsigned divide on magnitudes.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input int done);
    exp_t e;
    logic [31:0] mx, my, q, r;
    mx = x[31] ? 32'(0) - x : x;
    my = y[31] ? 32'(0) - y : y;
    if (my == 0) begin
      q = 32'hFFFF_FFFF;
      r = mx;
    end else begin
      q = mx / my;
      r = mx % my;
    end
    e.lo   = (x[31] ^ y[31]) ? 32'(0) - q : q;
    e.hi   = x[31] ? 32'(0) - r : r;
    e.zero = 1'b0;
    e.done = done;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset && DivStop) begin
      if (sb.size() == 0) begin
        check("spurious_stop", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("quotient", DivLO_out, e.lo);
        check("remainder", DivHI_out, e.hi);
        check("divzero", {31'b0, DivZero}, {31'b0, e.zero});
        check("done_cycle", 32'(cyc), 32'(e.done));
      end
    end
  end

  // Called at a negedge; returns one negedge after the start edge.
  task automatic issue(input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    e = model(x, y, cyc + 34);
`ifdef DIV_ZERO_DETECT_EN
    if (y == 0) begin
      e.lo   = last_lo;
      e.hi   = last_hi;
      e.zero = 1'b1;
      e.done = cyc + 1;
    end
`endif
    if (!e.zero) begin
      last_lo = e.lo;
      last_hi = e.hi;
    end
    sb.push_back(e);
    a = x;
    b = y;
    CtrlDiv = 1'b1;
    @(negedge clk);
    CtrlDiv = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int c;
    reset   = 1'b0;
    CtrlDiv = 1'b1;
    a       = 32'd100;
    b       = 32'd7;
    repeat (2) @(negedge clk);
    check("rst_stop", {31'b0, DivStop}, 32'd0);
    check("rst_zero", {31'b0, DivZero}, 32'd0);
    check("rst_hi", DivHI_out, 32'd0);
    check("rst_lo", DivLO_out, 32'd0);
    CtrlDiv = 1'b0;
    reset   = 1'b1;
    @(negedge clk);

    issue(32'd100, 32'd7);               drain();
    issue(32'hFFFF_FFF9, 32'd2);         drain();
    issue(32'd7, 32'hFFFF_FFFE);         drain();
    repeat (5) @(negedge clk);
    check("hold_lo", DivLO_out, last_lo);
    check("hold_hi", DivHI_out, last_hi);
    issue(32'h8000_0000, 32'hFFFF_FFFF); drain();
    issue(32'hFFFF_FF38, 32'd0);         drain();
    issue(32'd7, 32'd0);                 drain();
`ifdef DIV_ZERO_DETECT_EN
    check("zero_held", {31'b0, DivZero}, 32'd1);
    check("zero_keeps_lo", DivLO_out, last_lo);
`endif
    issue(32'd12345, 32'd0);             drain();

    // Abort in mid-run: no result, outputs cleared.
    issue(32'd100, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    last_lo = '0;
    last_hi = '0;
    check("abort_stop", {31'b0, DivStop}, 32'd0);
    check("abort_hi", DivHI_out, 32'd0);
    check("abort_lo", DivLO_out, 32'd0);
    check("abort_zero", {31'b0, DivZero}, 32'd0);
    repeat (40) @(negedge clk);
    issue(32'd9, 32'd3);                 drain();

    // Start requests during RUN must be ignored.
    issue(32'd100, 32'd7);
    repeat (4) @(negedge clk);
    CtrlDiv = 1'b1;
    a = 32'd1;
    b = 32'd1;
    @(negedge clk);
    CtrlDiv = 1'b0;
    drain();
    repeat (40) @(negedge clk);

    // CtrlDiv held high: second operation starts right after the first completes.
    c = cyc;
    sb.push_back(model(32'd100, 32'd7, c + 34));
    sb.push_back(model(32'hFFFF_FF9C, 32'd7, c + 68));
    a = 32'd100;
    b = 32'd7;
    CtrlDiv = 1'b1;
    @(negedge clk);
    a = 32'hFFFF_FF9C;
    while (cyc < c + 35) @(negedge clk);
    CtrlDiv = 1'b0;
    drain();
    repeat (5) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      issue($urandom, $urandom_range(1, 1000));
      drain();
    end
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule
